// File: rtl/pc_reg_pkg.sv
// rtl/pc_reg_pkg.sv - shared datapath constants for the program counter
package pc_reg_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_reg_dff_en_srst.sv
// rtl/pc_reg_dff_en_srst.sv - generic WIDTH-bit flop with enable and synchronous reset
module dff_en_srst #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Reset has priority over enable; otherwise hold
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_q <= RESET_VALUE;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - program-counter register for the single-cycle datapath
module pc_reg
    import pc_reg_pkg::*;
#(
    parameter int          WIDTH       = PC_WIDTH,
    parameter logic [63:0] RESET_VALUE = 64'(PC_RESET_VECTOR)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             LdEn,
    output logic [WIDTH-1:0] Dout
);

    // RESET_VALUE is carried wider than WIDTH so an oversized vector can be detected
    localparam logic [WIDTH-1:0] W_RESET_VALUE = RESET_VALUE[WIDTH-1:0];
    localparam bit               W_RESET_FITS  = (WIDTH >= 64) || ((RESET_VALUE >> WIDTH) == 64'd0);

    logic [WIDTH-1:0] w_pc;

    dff_en_srst #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (W_RESET_VALUE)
    ) u_pc_flop (
        .i_clk  (Clk),
        .i_srst (Reset),
        .i_en   (LdEn),
        .i_d    (Data),
        .o_q    (w_pc)
    );

    assign Dout = w_pc;

`ifndef SYNTHESIS
    logic r_seen_reset = 1'b0;

    // Track the first reset; afterwards controls must be known and the vector must fit
    always_ff @(posedge Clk) begin
        a_reset_fits: assert (W_RESET_FITS);
        if (r_seen_reset) begin
            a_ctrl_known: assert (!$isunknown({Reset, LdEn}));
        end
        if (Reset === 1'b1) begin
            r_seen_reset <= 1'b1;
        end
    end

    // Dout may only move as a consequence of a rising edge (Clk still high)
    always @(Dout) begin
        if (r_seen_reset) begin
            a_dout_edge_only: assert (Clk === 1'b1);
        end
    end
`endif

endmodule

// File: tb/tb_pc_reg.sv
// tb/tb_pc_reg.sv - self-checking bench for pc_reg against a behavioural PC model
`timescale 1ns/100ps
module tb_pc_reg;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] Data = 32'd31;
    logic        LdEn = 1'b0;
    logic [31:0] Dout;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_pc;

    pc_reg dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Data  (Data),
        .LdEn  (LdEn),
        .Dout  (Dout)
    );

    always #1 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply inputs just after an edge, advance one edge, update the model, check twice in the cycle
    task automatic cycle(input logic rst, input logic ld, input logic [31:0] d, input string tag);
        Reset = rst;
        LdEn  = ld;
        Data  = d;
        @(posedge Clk);
        if (rst) exp_pc = RV;
        else if (ld) exp_pc = d;
        #0.5;
        check_eq(tag, Dout, exp_pc);
        #1.0;
        check_eq({tag, "_stable"}, Dout, exp_pc);
    endtask

    initial begin
        // Align to just after an edge before driving
        @(posedge Clk);
        #0.5;

        // No load: PC content is undefined, only run the edges
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk);
        end
        #0.5;

        cycle(1'b0, 1'b1, 32'd31, "load31");
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 32'd31, "hold31");

        cycle(1'b1, 1'b1, 32'd31, "reset_over_load");
        cycle(1'b1, 1'b1, 32'd2,  "reset_ignores_data");
        cycle(1'b1, 1'b1, 32'd2,  "reset_held");
        cycle(1'b0, 1'b0, 32'd2,  "post_reset_hold");
        cycle(1'b0, 1'b0, 32'd2,  "post_reset_hold2");
        cycle(1'b0, 1'b1, 32'd2,  "load2");

        // Reset pulse entirely between edges must not take effect
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, "load_beef");
        LdEn = 1'b0;
        Reset = 1'b1;
        #0.4;
        check_eq("midcycle_reset_no_effect", Dout, exp_pc);
        Reset = 1'b0;
        #0.4;
        @(posedge Clk);
        #0.5;
        check_eq("after_midcycle_reset", Dout, exp_pc);

        cycle(1'b0, 1'b1, 32'hFFFF_FFFF, "load_all_ones");
        cycle(1'b0, 1'b1, 32'h0000_0003, "load_unaligned");
        cycle(1'b0, 1'b0, 32'h1234_5678, "hold_unaligned");

        // Randomized run against the model
        for (int i = 0; i < 300; i++) begin
            logic        r;
            logic        l;
            logic [31:0] d;
            r = ($urandom_range(0, 9) == 0);
            l = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0:       d = 32'h0000_0000;
                1:       d = 32'hFFFF_FFFF;
                default: d = $urandom;
            endcase
            cycle(r, l, d, "random");
        end

        Reset = 1'b0;
        LdEn  = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
